// File: rtl/msg_udp_rx_parser.sv
// GMII receive parser: checks preamble and the Ethernet/IPv4/UDP headers, then streams UDP payload bytes.
// Define MSG_RX_FCS_CHECK_EN to add CRC32 FCS checking; count publication then waits for the FCS result.
module msg_udp_rx_parser #(
  parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP    = 32'hC0A8_0002,
  parameter logic [15:0] BOARD_PORT  = 16'd1234,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        phy_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic        comm_ack_i,
  output logic        rec_en_o,
  output logic [7:0]  rec_data_o,
  output logic        rec_pkt_done_o,
  output logic        rec_byte_num_en_o,
  output logic [15:0] rec_byte_num_o,
  output logic        pkt_drop_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SR_W  = 40;

  localparam logic [CNT_W-1:0] UDP_HDR_LEN  = CNT_W'(8);
  localparam logic [CNT_W-1:0] ETH_MAC_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] ETH_LAST     = CNT_W'(13);
  localparam logic [CNT_W-1:0] IP_PROTO     = CNT_W'(9);
  localparam logic [CNT_W-1:0] IP_LAST      = CNT_W'(19);
  localparam logic [CNT_W-1:0] UDP_PORT_LO  = CNT_W'(3);
  localparam logic [CNT_W-1:0] UDP_LEN_LO   = CNT_W'(5);
  localparam logic [CNT_W-1:0] UDP_LAST     = CNT_W'(7);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH,
    ST_IP,
    ST_UDP,
    ST_DATA,
    ST_DONE,
    ST_WAIT_END,
    ST_DROP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [SR_W-1:0]  hdr_sr_q, hdr_sr_d;
  logic [CNT_W-1:0] udp_len_q, udp_len_d;
  logic [CNT_W-1:0] pay_len_q, pay_len_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             trunc_q, trunc_d;
  logic             dv_q;

  logic             rec_en_d;
  logic [7:0]       rec_data_d;
  logic             done_d;
  logic             num_en_d;
  logic [CNT_W-1:0] num_d;
  logic             drop_d;
  logic             reject;
  logic             abort;

  // Header field windows: earlier bytes from the shift register plus the byte on the bus now.
  logic [47:0]      mac_win;
  logic [31:0]      ip_win;
  logic [15:0]      half_win;

  assign mac_win  = {hdr_sr_q, gmii_rxd};
  assign ip_win   = {hdr_sr_q[23:0], gmii_rxd};
  assign half_win = {hdr_sr_q[7:0], gmii_rxd};

`ifdef MSG_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] FCS_RESIDUE = 32'hC704_DD7B;

  logic [31:0] crc_q, crc_d;
  logic        fcs_pend_q, fcs_pend_d;
  logic        fcs_ok;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (CRC_POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // The reflected register holds the bit-reversed residue once the FCS has been folded in.
  assign fcs_ok = (rev32(crc_q) == FCS_RESIDUE);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_sr_d   = hdr_sr_q;
    udp_len_d  = udp_len_q;
    pay_len_d  = pay_len_q;
    pay_cnt_d  = pay_cnt_q;
    trunc_d    = trunc_q;
    rec_en_d   = 1'b0;
    rec_data_d = rec_data_o;
    done_d     = 1'b0;
    num_en_d   = rec_byte_num_en_o & ~comm_ack_i;
    num_d      = rec_byte_num_o;
    drop_d     = 1'b0;
    reject     = 1'b0;
    abort      = 1'b0;
`ifdef MSG_RX_FCS_CHECK_EN
    crc_d      = crc_q;
    fcs_pend_d = fcs_pend_q;
    if (state_q == ST_PREAMBLE && gmii_rx_dv && gmii_rxd == 8'hD5) begin
      crc_d = '1;
    end else if (gmii_rx_dv) begin
      crc_d = crc_step(crc_q, gmii_rxd);
    end
`endif

    if (gmii_rx_dv) begin
      hdr_sr_d   = {hdr_sr_q[SR_W-9:0], gmii_rxd};
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Only a fresh dv rising edge starts a frame, so a frame cut by reset is ignored.
        if (gmii_rx_dv && !dv_q) begin
          byte_cnt_d = '0;
          if (gmii_rxd == 8'h55) state_d = ST_PREAMBLE;
          else                   reject  = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          abort = 1'b1;
        end else if (gmii_rxd == 8'hD5) begin
          state_d    = ST_ETH;
          byte_cnt_d = '0;
        end else if (gmii_rxd != 8'h55) begin
          reject = 1'b1;
        end
      end
      ST_ETH: begin
        if (!gmii_rx_dv) begin
          abort = 1'b1;
        end else begin
          if (byte_cnt_q == ETH_MAC_LAST && mac_win != BOARD_MAC && mac_win != '1) reject = 1'b1;
          if (byte_cnt_q == ETH_LAST) begin
            if (half_win != 16'h0800) begin
              reject = 1'b1;
            end else begin
              state_d    = ST_IP;
              byte_cnt_d = '0;
            end
          end
        end
      end
      ST_IP: begin
        if (!gmii_rx_dv) begin
          abort = 1'b1;
        end else begin
          if (byte_cnt_q == '0 && gmii_rxd != 8'h45)      reject = 1'b1;
          if (byte_cnt_q == IP_PROTO && gmii_rxd != 8'h11) reject = 1'b1;
          if (byte_cnt_q == IP_LAST) begin
            if (ip_win != BOARD_IP) begin
              reject = 1'b1;
            end else begin
              state_d    = ST_UDP;
              byte_cnt_d = '0;
            end
          end
        end
      end
      ST_UDP: begin
        if (!gmii_rx_dv) begin
          abort = 1'b1;
        end else begin
          if (byte_cnt_q == UDP_PORT_LO && half_win != BOARD_PORT) reject = 1'b1;
          if (byte_cnt_q == UDP_LEN_LO) udp_len_d = half_win;
          // Length guard runs first so the subtraction below cannot wrap.
          if (byte_cnt_q == UDP_LAST) begin
            if (udp_len_q <= UDP_HDR_LEN || (udp_len_q - UDP_HDR_LEN) > MAX_PAYLOAD ||
                rec_byte_num_en_o) begin
              reject = 1'b1;
            end else begin
              state_d   = ST_DATA;
              pay_len_d = udp_len_q - UDP_HDR_LEN;
              pay_cnt_d = '0;
              trunc_d   = 1'b0;
`ifdef MSG_RX_FCS_CHECK_EN
              fcs_pend_d = 1'b0;
`endif
            end
          end
        end
      end
      ST_DATA: begin
        if (gmii_rx_dv) begin
          rec_en_d   = 1'b1;
          rec_data_d = gmii_rxd;
          pay_cnt_d  = pay_cnt_q + CNT_W'(1);
          if (pay_cnt_q + CNT_W'(1) == pay_len_q) begin
`ifdef MSG_RX_FCS_CHECK_EN
            state_d    = ST_WAIT_END;
            fcs_pend_d = 1'b1;
`else
            state_d    = ST_DONE;
`endif
          end
        end else begin
          trunc_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        num_d   = pay_cnt_q;
        state_d = ST_WAIT_END;
`ifdef MSG_RX_FCS_CHECK_EN
        if (fcs_ok && !trunc_q) num_en_d = 1'b1;
        else                    drop_d   = 1'b1;
`else
        num_en_d = 1'b1;
        drop_d   = trunc_q;
`endif
      end
      ST_WAIT_END: begin
        if (!gmii_rx_dv) begin
`ifdef MSG_RX_FCS_CHECK_EN
          if (fcs_pend_q) begin
            state_d    = ST_DONE;
            fcs_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (reject) begin
      state_d = ST_DROP;
      drop_d  = 1'b1;
    end
    if (abort) begin
      state_d = ST_IDLE;
      drop_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge phy_rx_clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      byte_cnt_q        <= '0;
      hdr_sr_q          <= '0;
      udp_len_q         <= '0;
      pay_len_q         <= '0;
      pay_cnt_q         <= '0;
      trunc_q           <= 1'b0;
      // Held high through reset so a frame already in flight is not taken as a new one.
      dv_q              <= 1'b1;
      rec_en_o          <= 1'b0;
      rec_data_o        <= '0;
      rec_pkt_done_o    <= 1'b0;
      rec_byte_num_en_o <= 1'b0;
      rec_byte_num_o    <= '0;
      pkt_drop_o        <= 1'b0;
`ifdef MSG_RX_FCS_CHECK_EN
      crc_q             <= '1;
      fcs_pend_q        <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      byte_cnt_q        <= byte_cnt_d;
      hdr_sr_q          <= hdr_sr_d;
      udp_len_q         <= udp_len_d;
      pay_len_q         <= pay_len_d;
      pay_cnt_q         <= pay_cnt_d;
      trunc_q           <= trunc_d;
      dv_q              <= gmii_rx_dv;
      rec_en_o          <= rec_en_d;
      rec_data_o        <= rec_data_d;
      rec_pkt_done_o    <= done_d;
      rec_byte_num_en_o <= num_en_d;
      rec_byte_num_o    <= num_d;
      pkt_drop_o        <= drop_d;
`ifdef MSG_RX_FCS_CHECK_EN
      crc_q             <= crc_d;
      fcs_pend_q        <= fcs_pend_d;
`endif
    end
  end

endmodule
